// File: rtl/adder_frame_accumulator_if.sv
// Handshake bundle between wide_adder results, the frame accumulator and its consumer.
// master drives samples and out_ready; slave (the accumulator) drives in_ready and the frame result.
interface adder_frame_accumulator_if #(
    parameter int WIDTH     = 6,
    parameter int ACC_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_sum;
    logic                 in_carry;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_acc;
    logic                 out_ovf;

    modport master (
        output in_valid,
        output in_sum,
        output in_carry,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_acc,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_sum,
        input  in_carry,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_acc,
        output out_ovf
    );
endinterface

// File: rtl/adder_frame_accumulator.sv
// Sums COUNT {carry,sum} samples into a frame total; out_valid rises the cycle after the COUNT-th accept.
// in_ready is registered and drops for the whole DONE state, so a held result stalls the adder pipeline.
module adder_frame_accumulator #(
    parameter int WIDTH     = 6,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    adder_frame_accumulator_if.slave      io_bus
);
    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic [ACC_WIDTH-1:0] r_out_acc;
    logic [ACC_WIDTH-1:0] w_out_acc_nxt;
    logic                 r_ovf;
    logic                 w_ovf_nxt;
    logic                 r_out_ovf;
    logic                 w_out_ovf_nxt;
    logic                 r_in_ready;

    logic                 w_accept;
    logic                 w_last;
    logic [ACC_WIDTH-1:0] w_sample;
    logic [ACC_WIDTH-1:0] w_base;
    logic                 w_ovf_base;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_sum_ovf;

    assign w_accept  = io_bus.in_valid & r_in_ready;
    assign w_sample  = ACC_WIDTH'({io_bus.in_carry, io_bus.in_sum});
    // The first sample of a frame starts from zero, so IDLE and ACCUM share one adder.
    assign w_base     = (r_state == ACCUM) ? r_acc : '0;
    assign w_ovf_base = (r_state == ACCUM) & r_ovf;
    assign w_sum      = {1'b0, w_base} + {1'b0, w_sample};
    assign w_sum_ovf  = w_ovf_base | w_sum[ACC_WIDTH];
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_last     = (w_cnt_inc == CNT_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_acc_nxt     = r_acc;
        w_ovf_nxt     = r_ovf;
        w_out_acc_nxt = r_out_acc;
        w_out_ovf_nxt = r_out_ovf;
        unique case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = w_sum[ACC_WIDTH-1:0];
                    w_ovf_nxt = w_sum_ovf;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_last) begin
                        w_state_nxt   = DONE;
                        w_out_acc_nxt = w_sum[ACC_WIDTH-1:0];
                        w_out_ovf_nxt = w_sum_ovf;
                    end else begin
                        w_state_nxt = ACCUM;
                    end
                end
            end
            DONE: begin
                if (io_bus.out_ready) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // in_ready is a flop so it stays low through reset and has no path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_out_acc  <= '0;
            r_out_ovf  <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_acc      <= w_acc_nxt;
            r_ovf      <= w_ovf_nxt;
            r_out_acc  <= w_out_acc_nxt;
            r_out_ovf  <= w_out_ovf_nxt;
            r_in_ready <= (w_state_nxt != DONE);
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = (r_state == DONE);
    assign io_bus.out_acc   = r_out_acc;
    assign io_bus.out_ovf   = r_out_ovf;

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= CNT_LAST);
    a_no_ready_in_done: assert property (@(posedge clk) disable iff (!rst_n)
        !(io_bus.in_ready && io_bus.out_valid));
    a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
        (io_bus.out_valid && !io_bus.out_ready) |=>
            (io_bus.out_valid && $stable(io_bus.out_acc) && $stable(io_bus.out_ovf)));
endmodule

// File: tb/tb_adder_frame_accumulator.sv
// Directed bench: default build, an 8-bit accumulator build for wrap, and a COUNT=1 build fed by an adder model.
module tb_adder_frame_accumulator;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic        drv_valid  [3];
    logic [5:0]  drv_sum    [3];
    logic        drv_carry  [3];
    logic        drv_oready [3];
    logic        obs_in_ready  [3];
    logic        obs_out_valid [3];
    logic [15:0] obs_acc       [3];
    logic        obs_ovf       [3];

    adder_frame_accumulator_if #(.WIDTH(6), .ACC_WIDTH(16)) if0 ();
    adder_frame_accumulator_if #(.WIDTH(6), .ACC_WIDTH(8))  if1 ();
    adder_frame_accumulator_if #(.WIDTH(6), .ACC_WIDTH(16)) if2 ();

    adder_frame_accumulator #(.WIDTH(6), .ACC_WIDTH(16), .COUNT(8)) u_dflt (.clk(clk), .rst_n(rst_n), .io_bus(if0));
    adder_frame_accumulator #(.WIDTH(6), .ACC_WIDTH(8),  .COUNT(8)) u_wrap (.clk(clk), .rst_n(rst_n), .io_bus(if1));
    adder_frame_accumulator #(.WIDTH(6), .ACC_WIDTH(16), .COUNT(1)) u_one  (.clk(clk), .rst_n(rst_n), .io_bus(if2));

    assign if0.in_valid  = drv_valid[0];
    assign if0.in_sum    = drv_sum[0];
    assign if0.in_carry  = drv_carry[0];
    assign if0.out_ready = drv_oready[0];
    assign if1.in_valid  = drv_valid[1];
    assign if1.in_sum    = drv_sum[1];
    assign if1.in_carry  = drv_carry[1];
    assign if1.out_ready = drv_oready[1];
    assign if2.in_valid  = drv_valid[2];
    assign if2.in_sum    = drv_sum[2];
    assign if2.in_carry  = drv_carry[2];
    assign if2.out_ready = drv_oready[2];

    assign obs_in_ready[0]  = if0.in_ready;
    assign obs_in_ready[1]  = if1.in_ready;
    assign obs_in_ready[2]  = if2.in_ready;
    assign obs_out_valid[0] = if0.out_valid;
    assign obs_out_valid[1] = if1.out_valid;
    assign obs_out_valid[2] = if2.out_valid;
    assign obs_acc[0]       = if0.out_acc;
    assign obs_acc[1]       = {8'h00, if1.out_acc};
    assign obs_acc[2]       = if2.out_acc;
    assign obs_ovf[0]       = if0.out_ovf;
    assign obs_ovf[1]       = if1.out_ovf;
    assign obs_ovf[2]       = if2.out_ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until the stage accepts it (bounded wait).
    task automatic push(input int d, input logic [6:0] v);
        int waited;
        waited = 0;
        drv_valid[d] = 1'b1;
        drv_sum[d]   = v[5:0];
        drv_carry[d] = v[6];
        while (!obs_in_ready[d] && waited < 20) begin
            tick();
            waited++;
        end
        chk_eq("push_in_ready", obs_in_ready[d], 1);
        tick();
        drv_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        drv_oready[d] = 1'b1;
        tick();
        drv_oready[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] a;
        logic [5:0] b;
        logic       c;
        logic [6:0] adder_out;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv_valid[i]  = 1'b0;
            drv_sum[i]    = '0;
            drv_carry[i]  = 1'b0;
            drv_oready[i] = 1'b0;
        end
        tick();
        tick();
        chk_eq("rst_out_valid", obs_out_valid[0], 0);
        chk_eq("rst_in_ready",  obs_in_ready[0],  0);
        chk_eq("rst_out_acc",   obs_acc[0],       0);
        chk_eq("rst_out_ovf",   obs_ovf[0],       0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_eq("post_rst_in_ready", obs_in_ready[0], 1);

        // Back-to-back: 8 x 127
        for (int i = 0; i < 8; i++) begin
            push(0, 7'd127);
            if (i == 6) chk_eq("b2b_not_early", obs_out_valid[0], 0);
        end
        chk_eq("b2b_out_valid", obs_out_valid[0], 1);
        chk_eq("b2b_out_acc",   obs_acc[0],       1016);
        chk_eq("b2b_out_ovf",   obs_ovf[0],       0);
        chk_eq("b2b_in_ready",  obs_in_ready[0],  0);

        // Backpressure with a pending sample of 5
        drv_valid[0] = 1'b1;
        drv_sum[0]   = 6'd5;
        drv_carry[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_eq("bp_out_valid", obs_out_valid[0], 1);
            chk_eq("bp_out_acc",   obs_acc[0],       1016);
            chk_eq("bp_in_ready",  obs_in_ready[0],  0);
        end
        drain(0);
        drv_valid[0] = 1'b1;
        chk_eq("bp_released_valid", obs_out_valid[0], 0);
        chk_eq("bp_held_acc",       obs_acc[0],       1016);
        chk_eq("bp_ready_back",     obs_in_ready[0],  1);
        for (int i = 0; i < 8; i++) push(0, 7'd5);
        chk_eq("bp_next_valid", obs_out_valid[0], 1);
        chk_eq("bp_next_acc",   obs_acc[0],       40);
        drain(0);

        // Gapped input 0..7, junk on the bus while in_valid=0
        for (int i = 0; i < 8; i++) begin
            drv_valid[0] = 1'b1;
            drv_sum[0]   = 6'(i);
            drv_carry[0] = 1'b0;
            tick();
            chk_eq("gap_out_valid", obs_out_valid[0], (i == 7) ? 1 : 0);
            drv_valid[0] = 1'b0;
            drv_sum[0]   = 6'd63;
            drv_carry[0] = 1'b1;
            tick();
        end
        chk_eq("gap_out_acc", obs_acc[0], 28);
        chk_eq("gap_out_ovf", obs_ovf[0], 0);
        drain(0);

        // Wrap in the 8-bit build
        for (int i = 0; i < 8; i++) push(1, 7'd127);
        chk_eq("ovf_out_valid", obs_out_valid[1], 1);
        chk_eq("ovf_out_acc",   obs_acc[1],       248);
        chk_eq("ovf_out_ovf",   obs_ovf[1],       1);
        drain(1);
        for (int i = 0; i < 8; i++) push(1, 7'd1);
        chk_eq("ovf_next_acc", obs_acc[1], 8);
        chk_eq("ovf_next_ovf", obs_ovf[1], 0);
        drain(1);

        // COUNT=1 fed by an adder model
        a = 6'd10; b = 6'd20; c = 1'b1;
        adder_out = {1'b0, a} + {1'b0, b} + {6'd0, c};
        chk_eq("one_idle_valid", obs_out_valid[2], 0);
        push(2, adder_out);
        chk_eq("one_out_valid", obs_out_valid[2], 1);
        chk_eq("one_out_acc",   obs_acc[2],       31);
        drain(2);
        a = 6'd63; b = 6'd63; c = 1'b1;
        adder_out = {1'b0, a} + {1'b0, b} + {6'd0, c};
        push(2, adder_out);
        chk_eq("one_max_acc", obs_acc[2], 127);
        chk_eq("one_max_ovf", obs_ovf[2], 0);
        drain(2);

        // Reset in the middle of a frame
        for (int i = 0; i < 3; i++) push(0, 7'd9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_out_valid", obs_out_valid[0], 0);
        chk_eq("mid_rst_in_ready",  obs_in_ready[0],  0);
        chk_eq("mid_rst_out_acc",   obs_acc[0],       0);
        chk_eq("mid_rst_wrap_acc",  obs_acc[1],       0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_eq("mid_rst_ready_back", obs_in_ready[0], 1);
        for (int i = 0; i < 8; i++) begin
            push(0, 7'd2);
            if (i == 4) chk_eq("mid_rst_no_stale_done", obs_out_valid[0], 0);
        end
        chk_eq("mid_rst_frame_valid", obs_out_valid[0], 1);
        chk_eq("mid_rst_frame_acc",   obs_acc[0],       16);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_frame_accumulator.md
Name: adder_frame_accumulator

Overview:
- Stage directly downstream of wide_adder. Consumes its sum and carry-out as one (WIDTH+1)-bit value.
- Accumulates COUNT accepted results into a frame total and presents the total with a valid/ready handshake.
- Input side uses valid/ready so the adder pipeline can be stalled.

Parameters:
- WIDTH, 6: operand width of the upstream wide_adder; in_sum width.
- ACC_WIDTH, 16: accumulator and output width. Must be >= WIDTH+1.
- COUNT, 8: accepted samples per frame. Must be >= 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream adder result is valid.
- in_ready  output  1  stage can accept a result this cycle.
- in_sum  input  WIDTH  sum output of wide_adder.
- in_carry  input  1  carry-out of wide_adder.
- out_valid  output  1  frame total available.
- out_ready  input  1  downstream consumes the frame total.
- out_acc  output  ACC_WIDTH  frame total, modulo 2^ACC_WIDTH.
- out_ovf  output  1  sticky flag: the frame total wrapped at least once.

Behaviour:
- Sample value = {in_carry, in_sum}, zero-extended to ACC_WIDTH. Range 0..2^(WIDTH+1)-1.
- Accept occurs when in_valid && in_ready at a rising edge. Outside an accept, in_sum and in_carry are ignored.
- Reset state (asynchronous, while rst_n=0): state=IDLE, cnt=0, acc=0, out_acc=0, out_ovf=0, out_valid=0, in_ready=0.
- in_ready is a function of registered state only. It is 1 in IDLE and ACCUM, and 0 in DONE and during reset. There is no combinational path from out_ready or in_valid to in_ready.
- IDLE:
  - On accept: acc <= sample, ovf <= 0, cnt <= 1. Next state is DONE if COUNT==1, otherwise ACCUM.
  - With no accept: no state change.
- ACCUM:
  - On accept: compute acc + sample at ACC_WIDTH+1 bits. acc <= low ACC_WIDTH bits; ovf <= ovf | bit ACC_WIDTH; cnt <= cnt+1.
  - On the accept where cnt == COUNT-1 (the COUNT-th sample), go to DONE.
  - Idle cycles (in_valid=0) hold all state. There is no timeout.
- DONE:
  - out_valid=1. out_acc and out_ovf show the frame result and stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE. cnt <= 0, out_valid <= 0. out_acc and out_ovf keep their last value until the next frame completes.
- Latency: out_valid rises on the rising edge that performs the COUNT-th accept, i.e. it is visible in the cycle after that accept.
- Minimum frame period is COUNT+1 cycles: COUNT accepts plus one DONE cycle with out_ready=1. Back-to-back frames are supported with no extra bubble.
- in_valid held high while in DONE: the sample is not consumed. It is accepted in the first IDLE cycle as the first sample of the next frame.
- Counter cnt is ceil(log2(COUNT+1)) bits wide. It never exceeds COUNT.
- Reset mid-frame: the partial frame is discarded. After rst_n deasserts, the next frame is counted from the first post-reset accept.

Test Plan:
- Reset: assert rst_n=0 mid-cycle during ACCUM → immediately out_valid=0, in_ready=0, out_acc=0, out_ovf=0. After release, in_ready=1 on the next cycle.
- Back-to-back (defaults): 8 accepts of in_sum=63, in_carry=1 (value 127) → out_valid=1 in the cycle after the 8th accept, out_acc=1016, out_ovf=0.
- Gapped input: samples 0..7 with in_valid toggling every cycle → exactly 8 accepts, out_acc=28, no accept while in_valid=0.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and value 5 → out_valid, out_acc=1016 and in_ready=0 stable. Pulse out_ready, then 8 accepts of value 5 → next out_acc=40.
- Overflow (ACC_WIDTH=8): 8×127 → out_acc=248, out_ovf=1. Following frame of 8×1 → out_acc=8, out_ovf=0.
- COUNT=1 with wide_adder instantiated upstream (A=10, B=20, C=1) → out_valid in the cycle after a single accept, out_acc=31.
